// File: rtl/sha_round_sched.sv
// SHA-256 message-schedule generator and round counter paired with cu_sha.
// Optional build macro SHA_KT_ROM_EN adds the o_kt round-constant ROM output.
module sha_round_sched #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 6
) (
  input  logic             usr_clk,
  input  logic             usr_reset_n,
  input  logic             i_load,
  input  logic [511:0]     i_blk,
  input  logic             i_cnt_en,
  output logic             o_cnt_flag,
  output logic [CNT_W-1:0] o_round,
  output logic [31:0]      o_wt,
  output logic             o_busy
`ifdef SHA_KT_ROM_EN
  ,
  output logic [31:0]      o_kt
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_round;
  logic [31:0]      r_win [16];

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_round_nxt;
  logic             w_load;
  logic             w_shift;
  logic [31:0]      w_new_word;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign w_new_word = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

  // Next-state logic: a load pre-empts everything, including a pending advance.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    if (i_load) begin
      w_load      = 1'b1;
      w_state_nxt = S_RUN;
      w_round_nxt = '0;
    end else if (r_state == S_RUN && i_cnt_en) begin
      if (r_round == LAST_ROUND) begin
        w_state_nxt = S_IDLE;
        w_round_nxt = '0;
      end else begin
        w_round_nxt = r_round + 1'b1;
        w_shift     = 1'b1;
      end
    end
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state <= S_IDLE;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      // NOTE: the window is reset so o_wt reads zero after reset rather than stale data.
      for (int k = 0; k < 16; k++) r_win[k] <= '0;
    end else if (w_load) begin
      for (int k = 0; k < 16; k++) r_win[k] <= i_blk[511 - 32*k -: 32];
    end else if (w_shift) begin
      for (int k = 0; k < 15; k++) r_win[k] <= r_win[k+1];
      r_win[15] <= w_new_word;
    end
  end

  assign o_round    = r_round;
  assign o_wt       = r_win[0];
  assign o_busy     = (r_state == S_RUN);
  assign o_cnt_flag = (r_state == S_RUN) && (r_round == LAST_ROUND);

`ifdef SHA_KT_ROM_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [5:0] w_kt_idx;
  assign w_kt_idx = 6'(r_round);
  assign o_kt     = K_ROM[w_kt_idx];
`endif

endmodule

// File: tb/tb_sha_round_sched.sv
// Directed bench for sha_round_sched: reset, "abc" schedule, flag timing, stalls,
// load collision/restart and idle behaviour; reference schedule built from the block.
module tb_sha_round_sched;

  logic         usr_clk;
  logic         usr_reset_n;
  logic         i_load;
  logic [511:0] i_blk;
  logic         i_cnt_en;
  logic         o_cnt_flag;
  logic [5:0]   o_round;
  logic [31:0]  o_wt;
  logic         o_busy;
`ifdef SHA_KT_ROM_EN
  logic [31:0]  o_kt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]  exp_w [64];
  logic [511:0] blk_abc;
  logic [511:0] blk_b;

  sha_round_sched #(.ROUNDS(64), .CNT_W(6)) dut (
    .usr_clk     (usr_clk),
    .usr_reset_n (usr_reset_n),
    .i_load      (i_load),
    .i_blk       (i_blk),
    .i_cnt_en    (i_cnt_en),
    .o_cnt_flag  (o_cnt_flag),
    .o_round     (o_round),
    .o_wt        (o_wt),
    .o_busy      (o_busy)
`ifdef SHA_KT_ROM_EN
    ,
    .o_kt        (o_kt)
`endif
  );

  initial usr_clk = 1'b0;
  always #5 usr_clk = ~usr_clk;

  function automatic logic [31:0] tb_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 array-form schedule for the block.
  task automatic build_sched(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = tb_rotr(exp_w[t-15], 7) ^ tb_rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = tb_rotr(exp_w[t-2], 17) ^ tb_rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  // Inputs change on the falling edge; the rising edge then captures them.
  task automatic load_block(input logic [511:0] b, input logic en);
    i_blk    = b;
    i_load   = 1'b1;
    i_cnt_en = en;
    @(negedge usr_clk);
    i_load   = 1'b0;
  endtask

  task automatic test_reset;
    int guard;
    load_block(blk_abc, 1'b1);
    guard = 0;
    while (o_round != 6'd17 && guard < 100) begin
      @(negedge usr_clk);
      guard++;
    end
    i_cnt_en = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_pre_busy got %b exp 1", o_busy);
    end
    @(posedge usr_clk);
    #3 usr_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (o_round !== 6'd0) begin
      n_bad++; $display("FAIL reset_round got %0d exp 0", o_round);
    end
    n_cmp++;
    if (o_wt !== 32'h0) begin
      n_bad++; $display("FAIL reset_wt got %h exp 00000000", o_wt);
    end
    n_cmp++;
    if (o_cnt_flag !== 1'b0) begin
      n_bad++; $display("FAIL reset_flag got %b exp 0", o_cnt_flag);
    end
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b exp 0", o_busy);
    end
`ifdef SHA_KT_ROM_EN
    n_cmp++;
    if (o_kt !== 32'h428A2F98) begin
      n_bad++; $display("FAIL reset_kt got %h exp 428a2f98", o_kt);
    end
`endif
    @(negedge usr_clk);
    usr_reset_n = 1'b1;
    @(negedge usr_clk);
  endtask

  // "abc" block with cnt_en held high; covers schedule values and flag timing.
  task automatic test_abc_schedule;
    int t;
    int n_en;
    build_sched(blk_abc);
    load_block(blk_abc, 1'b1);
    t = 0;
    n_en = 0;
    while (o_busy && n_en < 100) begin
      n_cmp++;
      if (o_round !== 6'(t)) begin
        n_bad++; $display("FAIL abc_round got %0d exp %0d", o_round, t);
      end
      n_cmp++;
      if (o_wt !== exp_w[t % 64]) begin
        n_bad++; $display("FAIL abc_wt t=%0d got %h exp %h", t, o_wt, exp_w[t % 64]);
      end
      n_cmp++;
      if (o_cnt_flag !== (t == 63)) begin
        n_bad++; $display("FAIL abc_flag t=%0d got %b exp %b", t, o_cnt_flag, (t == 63));
      end
      case (t)
        0:  begin n_cmp++; if (o_wt !== 32'h61626380) begin n_bad++; $display("FAIL abc_w0 got %h exp 61626380", o_wt); end end
        15: begin n_cmp++; if (o_wt !== 32'h00000018) begin n_bad++; $display("FAIL abc_w15 got %h exp 00000018", o_wt); end end
        16: begin n_cmp++; if (o_wt !== 32'h61626380) begin n_bad++; $display("FAIL abc_w16 got %h exp 61626380", o_wt); end end
        17: begin n_cmp++; if (o_wt !== 32'h000F0000) begin n_bad++; $display("FAIL abc_w17 got %h exp 000f0000", o_wt); end end
        18: begin n_cmp++; if (o_wt !== 32'h7DA86405) begin n_bad++; $display("FAIL abc_w18 got %h exp 7da86405", o_wt); end end
        63: begin n_cmp++; if (o_wt !== 32'h12B1EDEB) begin n_bad++; $display("FAIL abc_w63 got %h exp 12b1edeb", o_wt); end end
        default: ;
      endcase
`ifdef SHA_KT_ROM_EN
      if (t == 0) begin
        n_cmp++;
        if (o_kt !== 32'h428A2F98) begin n_bad++; $display("FAIL kt_t0 got %h exp 428a2f98", o_kt); end
      end
      if (t == 63) begin
        n_cmp++;
        if (o_kt !== 32'hC67178F2) begin n_bad++; $display("FAIL kt_t63 got %h exp c67178f2", o_kt); end
      end
`endif
      i_cnt_en = 1'b1;
      @(negedge usr_clk);
      t++;
      n_en++;
    end
    n_cmp++;
    if (n_en !== 64) begin
      n_bad++; $display("FAIL abc_enabled_cycles got %0d exp 64", n_en);
    end
    n_cmp++;
    if (o_round !== 6'd0 || o_cnt_flag !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL abc_end got round=%0d flag=%b busy=%b exp 0/0/0", o_round, o_cnt_flag, o_busy);
    end
    i_cnt_en = 1'b0;
  endtask

  task automatic test_stall;
    int t;
    int st20;
    int st63;
    int guard;
    build_sched(blk_abc);
    load_block(blk_abc, 1'b1);
    t = 0; st20 = 0; st63 = 0; guard = 0;
    while (o_busy && guard < 200) begin
      n_cmp++;
      if (o_round !== 6'(t) || o_wt !== exp_w[t % 64]) begin
        n_bad++; $display("FAIL stall_hold t=%0d got round=%0d wt=%h exp wt=%h", t, o_round, o_wt, exp_w[t % 64]);
      end
      if (t == 20 && st20 < 5) begin
        i_cnt_en = 1'b0;
        st20++;
      end else if (t == 63 && st63 < 3) begin
        i_cnt_en = 1'b0;
        st63++;
        n_cmp++;
        if (o_cnt_flag !== 1'b1) begin
          n_bad++; $display("FAIL stall_flag cycle=%0d got %b exp 1", st63, o_cnt_flag);
        end
      end else begin
        if (t == 63) begin
          n_cmp++;
          if (o_wt !== 32'h12B1EDEB) begin n_bad++; $display("FAIL stall_w63 got %h exp 12b1edeb", o_wt); end
        end
        i_cnt_en = 1'b1;
        t++;
      end
      @(negedge usr_clk);
      guard++;
    end
    n_cmp++;
    if (t !== 64 || st20 !== 5 || st63 !== 3) begin
      n_bad++; $display("FAIL stall_progress got t=%0d st20=%0d st63=%0d exp 64/5/3", t, st20, st63);
    end
    i_cnt_en = 1'b0;
  endtask

  task automatic test_collision;
    int guard;
    int t;
    int n_flag;
    load_block(blk_abc, 1'b1);
    guard = 0;
    n_flag = 0;
    while (o_round != 6'd30 && guard < 100) begin
      if (o_cnt_flag) n_flag++;
      @(negedge usr_clk);
      guard++;
    end
    n_cmp++;
    if (o_round !== 6'd30) begin
      n_bad++; $display("FAIL coll_reach30 got %0d exp 30", o_round);
    end
    build_sched(blk_b);
    load_block(blk_b, 1'b1);
    n_cmp++;
    if (o_round !== 6'd0 || o_wt !== exp_w[0] || o_busy !== 1'b1) begin
      n_bad++; $display("FAIL coll_restart got round=%0d wt=%h busy=%b exp 0/%h/1", o_round, o_wt, o_busy, exp_w[0]);
    end
    t = 0;
    guard = 0;
    while (o_busy && guard < 100) begin
      if (o_cnt_flag) n_flag++;
      n_cmp++;
      if (o_wt !== exp_w[t % 64] || o_cnt_flag !== (t == 63)) begin
        n_bad++; $display("FAIL coll_newblk t=%0d got wt=%h flag=%b exp %h/%b", t, o_wt, o_cnt_flag, exp_w[t % 64], (t == 63));
      end
      @(negedge usr_clk);
      t++;
      guard++;
    end
    n_cmp++;
    if (n_flag !== 1 || t !== 64) begin
      n_bad++; $display("FAIL coll_flags got flags=%0d rounds=%0d exp 1/64", n_flag, t);
    end
    i_cnt_en = 1'b0;
  endtask

  task automatic test_idle_cnt_en;
    i_cnt_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge usr_clk);
      n_cmp++;
      if (o_round !== 6'd0 || o_busy !== 1'b0 || o_cnt_flag !== 1'b0) begin
        n_bad++; $display("FAIL idle_en c=%0d got round=%0d busy=%b flag=%b exp 0/0/0", c, o_round, o_busy, o_cnt_flag);
      end
`ifdef SHA_KT_ROM_EN
      n_cmp++;
      if (o_kt !== 32'h428A2F98) begin n_bad++; $display("FAIL idle_kt got %h exp 428a2f98", o_kt); end
`endif
    end
    i_cnt_en = 1'b0;
  endtask

  initial begin
    blk_abc = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    for (int k = 0; k < 16; k++) blk_b[511 - 32*k -: 32] = 32'h9E3779B9 * (k + 1);
    usr_reset_n = 1'b0;
    i_load      = 1'b0;
    i_blk       = '0;
    i_cnt_en    = 1'b0;
    repeat (2) @(negedge usr_clk);
    usr_reset_n = 1'b1;
    @(negedge usr_clk);

    test_reset;
    test_abc_schedule;
    test_stall;
    test_collision;
    test_idle_cnt_en;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
